// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: state encoding and fetch constants.
package if_fetch_ctrl_pkg;

   localparam int INST_W = 32;
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t ST_IDLE   = 2'd0;
   localparam fetch_state_t ST_REQ    = 2'd1;
   localparam fetch_state_t ST_UPDATE = 2'd2;
   localparam fetch_state_t ST_HOLD   = 2'd3;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: req/ack fetch at pc_i, PC write-back, stall and redirect arbitration.
// Optional build macro FETCH_TIMEOUT_EN adds an ack timeout with a sticky fetch_err_o flag.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       pc_i,
   output logic              pc_write_o,
   output logic [31:0]       pc_next_o,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [31:0]       redirect_pc_i,
   output logic              imem_req_o,
   output logic [31:0]       imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [INST_W-1:0] imem_rdata_i,
   output logic [INST_W-1:0] inst_o,
   output logic [31:0]       inst_pc_o,
   output logic              inst_valid_o,
`ifdef FETCH_TIMEOUT_EN
   output logic              fetch_err_o,
`endif
   output fetch_state_t      dbg_state_o
);

   fetch_state_t state;
   fetch_state_t nxt;
   logic         kill;
   logic         kill_now;
   logic [31:0]  tgt;
   logic [31:0]  tgt_now;
   logic [31:0]  upd_pc;
   logic         timeout_hit;

   // A redirect arriving this cycle counts immediately, so it can win over a same-cycle ack or stall.
   assign kill_now    = kill | redirect_i;
   assign tgt_now     = redirect_i ? redirect_pc_i : tgt;
   assign imem_req_o  = (state == ST_REQ);
   assign dbg_state_o = state;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt;

   assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wait_cnt    <= '0;
         fetch_err_o <= 1'b0;
      end else begin
         if (state != ST_REQ || imem_ack_i) begin
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (state == ST_REQ && !imem_ack_i && timeout_hit) begin
            fetch_err_o <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;

   // TIMEOUT_CYCLES only shapes the timeout build; keep a range guard so it is referenced here too.
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
   end
`endif

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE: nxt = ST_REQ;
         ST_REQ: begin
            if (imem_ack_i) begin
               nxt = (!stall_i || kill_now) ? ST_UPDATE : ST_HOLD;
            end else if (timeout_hit) begin
               nxt = ST_UPDATE;
            end
         end
         ST_HOLD: begin
            if (!stall_i || kill_now) begin
               nxt = ST_UPDATE;
            end
         end
         default: nxt = ST_REQ;
      endcase
   end

   // From REQ the fetched PC is still on pc_i; from HOLD it has been captured in inst_pc_o.
   always_comb begin
      if (kill_now) begin
         upd_pc = tgt_now;
      end else if (state == ST_HOLD) begin
         upd_pc = inst_pc_o + PC_STEP;
      end else if (imem_ack_i) begin
         upd_pc = pc_i + PC_STEP;
      end else begin
         upd_pc = pc_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= ST_IDLE;
         kill         <= 1'b0;
         tgt          <= '0;
         imem_addr_o  <= '0;
         pc_write_o   <= 1'b0;
         pc_next_o    <= RESET_PC;
         inst_o       <= '0;
         inst_pc_o    <= '0;
         inst_valid_o <= 1'b0;
      end else begin
         state <= nxt;
         if (state == ST_UPDATE) begin
            kill <= redirect_i;
         end else if (redirect_i) begin
            kill <= 1'b1;
         end
         if (redirect_i) begin
            tgt <= redirect_pc_i;
         end
         if (state == ST_REQ && imem_ack_i) begin
            inst_o    <= imem_rdata_i;
            inst_pc_o <= pc_i;
         end
         pc_write_o   <= (nxt == ST_UPDATE);
         inst_valid_o <= (nxt == ST_UPDATE) && !kill_now && !(state == ST_REQ && !imem_ack_i);
         if (nxt == ST_UPDATE) begin
            pc_next_o <= upd_pc;
         end
         // Address register tracks the value the PC register holds during the coming REQ.
         if (state == ST_IDLE) begin
            imem_addr_o <= pc_i;
         end else if (state == ST_UPDATE) begin
            imem_addr_o <= pc_next_o;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized bench for if_fetch_ctrl with a PC register, a latency-programmable memory and a fetch-stream reference model.
module tb_if_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          TMO      = 16;
`ifdef FETCH_TIMEOUT_EN
   localparam bit          TMO_EN   = 1'b1;
`else
   localparam bit          TMO_EN   = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_reg;
   logic        pc_write_o;
   logic [31:0] pc_next_o;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_valid_o;
   logic [1:0]  dbg_state;
`ifdef FETCH_TIMEOUT_EN
   logic        fetch_err_o;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: fetches completed but not yet written back, as {pc, inst, timed_out}.
   logic [64:0] exp_q[$];
   logic        m_kill;
   logic [31:0] m_tgt;
   logic        m_wait_upd;
   logic        m_err;
   logic        exp_upd;
   logic        exp_req;
   int          mem_wait;

   if_fetch_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .pc_i         (pc_reg),
      .pc_write_o   (pc_write_o),
      .pc_next_o    (pc_next_o),
      .stall_i      (stall),
      .redirect_i   (redirect),
      .redirect_pc_i(redirect_pc),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack),
      .imem_rdata_i (imem_rdata),
      .inst_o       (inst_o),
      .inst_pc_o    (inst_pc_o),
      .inst_valid_o (inst_valid_o),
`ifdef FETCH_TIMEOUT_EN
      .fetch_err_o  (fetch_err_o),
`endif
      .dbg_state_o  (dbg_state)
   );

   always #5 clk = ~clk;

   // PC register on the producing side.
   always @(posedge clk) begin
      if (rst) pc_reg <= RESET_PC;
      else if (pc_write_o) pc_reg <= pc_next_o;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h8C01_0004;
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input logic rd, input logic [31:0] rpc);
      @(negedge clk);
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
      @(negedge clk);
      check("rst_req", 32'(imem_req_o), 32'd0);
      check("rst_addr", imem_addr_o, 32'd0);
      check("rst_pc_write", 32'(pc_write_o), 32'd0);
      check("rst_pc_next", pc_next_o, RESET_PC);
      check("rst_inst", inst_o, 32'd0);
      check("rst_inst_pc", inst_pc_o, 32'd0);
      check("rst_valid", 32'(inst_valid_o), 32'd0);
`ifdef FETCH_TIMEOUT_EN
      check("rst_err", 32'(fetch_err_o), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0; redirect = rd; redirect_pc = rpc;
      exp_q.delete();
      m_kill = rd; m_tgt = rpc; m_wait_upd = 1'b0; m_err = 1'b0;
      mem_wait = 0; exp_upd = 1'b0; exp_req = 1'b1;
   endtask

   // One cycle: check what the DUT shows, then drive inputs and advance the model.
   task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input int lat, input logic junk);
      logic        ack_now;
      logic        tmo;
      logic [64:0] head;
      @(negedge clk);
      check("pc_write", 32'(pc_write_o), 32'(exp_upd));
      check("req", 32'(imem_req_o), 32'(exp_req));
      if (imem_req_o) check("addr", imem_addr_o, pc_reg);
`ifdef FETCH_TIMEOUT_EN
      check("fetch_err", 32'(fetch_err_o), 32'(m_err));
`endif
      if (pc_write_o) begin
         if (exp_q.size() == 0) begin
            check("upd_spurious", 32'(pc_write_o), 32'd0);
         end else begin
            head = exp_q.pop_front();
            check("inst_valid", 32'(inst_valid_o), 32'(!m_kill && !head[0]));
            check("pc_next", pc_next_o, m_kill ? m_tgt : (head[0] ? head[64:33] : head[64:33] + 32'd4));
            if (!m_kill && !head[0]) begin
               check("inst", inst_o, head[32:1]);
               check("inst_pc", inst_pc_o, head[64:33]);
            end
         end
         m_kill = 1'b0;
      end
      stall = st;
      redirect = rd;
      redirect_pc = rd ? rpc : $urandom;
      if (rd) begin
         m_kill = 1'b1;
         m_tgt = rpc;
      end
      ack_now = 1'b0;
      tmo = 1'b0;
      if (imem_req_o) begin
         if (mem_wait >= lat) begin
            ack_now = 1'b1;
            mem_wait = 0;
         end else begin
            mem_wait++;
            if (TMO_EN && mem_wait == TMO) begin
               tmo = 1'b1;
               mem_wait = 0;
            end
         end
      end else begin
         ack_now = junk;
      end
      imem_ack = ack_now;
      imem_rdata = (imem_req_o && ack_now) ? mem_word(pc_reg) : $urandom;
      if (imem_req_o && ack_now) begin
         exp_q.push_back({pc_reg, mem_word(pc_reg), 1'b0});
         m_wait_upd = 1'b1;
      end
      if (tmo) begin
         exp_q.push_back({pc_reg, 32'h0, 1'b1});
         m_wait_upd = 1'b1;
         m_err = 1'b1;
      end
      exp_req = pc_write_o || (imem_req_o && !ack_now && !tmo);
      exp_upd = m_wait_upd && (!st || m_kill || tmo);
      if (exp_upd) m_wait_upd = 1'b0;
   endtask

   initial begin
      // zero-wait memory: one instruction every two cycles
      do_reset(1'b0, 32'h0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 0, 1'b0);
      // ack delayed by three cycles
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 3, 1'b0);
      // stall held five cycles across the ack
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1, 1'b0);
      // reset while a request is waiting
      step(1'b0, 1'b0, 32'h0, 5, 1'b0);
      step(1'b0, 1'b0, 32'h0, 5, 1'b0);
      // redirect to 0x40 while waiting at 0x8
      do_reset(1'b0, 32'h0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 0, 1'b0);
      step(1'b0, 1'b1, 32'h40, 3, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 3, 1'b0);
      // redirect together with stall while holding
      do_reset(1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0, 0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 0, 1'b0);
      step(1'b1, 1'b1, 32'h80, 0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 0, 1'b0);
      // redirect during IDLE
      do_reset(1'b1, 32'h100);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 0, 1'b0);
`ifdef FETCH_TIMEOUT_EN
      // memory never answers: timeout, refetch of the same address
      do_reset(1'b0, 32'h0);
      for (int i = 0; i < 22; i++) step(1'b0, 1'b0, 32'h0, 40, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 0, 1'b0);
`endif
      // random traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset($urandom_range(0, 3) == 0, $urandom & 32'hFFFF_FFFC);
         end else begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 $urandom & 32'hFFFF_FFFC, $urandom_range(0, 4), $urandom_range(0, 3) == 0);
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller on the consuming side of the PC register. Each cycle it reads the current PC, issues a request/acknowledge read to instruction memory and captures the returned word for the IF/ID stage. It then drives the PC register's write-select and next-PC value, so the PC only advances when a fetch has completed. Stalls from the hazard unit and branch/jump redirects from later stages are arbitrated here.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: value driven on pc_next_o while in reset and IDLE.
- TIMEOUT_CYCLES, 16: wait cycles without ack before abort. Used only with the timeout feature.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- pc_i  in  32  current PC from the PC register output.
- pc_write_o  out  1  write-select to the PC register. PC loads pc_next_o at the edge where this is 1.
- pc_next_o  out  32  next PC value.
- stall_i  in  1  hazard-unit stall. While 1, no PC update and no new instruction is issued.
- redirect_i  in  1  taken branch/jump, single-cycle pulse.
- redirect_pc_i  in  32  redirect target; valid when redirect_i=1.
- imem_req_o  out  1  memory read request.
- imem_addr_o  out  32  memory read address.
- imem_ack_i  in  1  memory read complete.
- imem_rdata_i  in  32  read data; valid when imem_ack_i=1.
- inst_o  out  32  fetched instruction to IF/ID.
- inst_pc_o  out  32  PC of inst_o.
- inst_valid_o  out  1  inst_o/inst_pc_o valid, one-cycle pulse.
- fetch_err_o  out  1  timeout flag. Present only with FETCH_TIMEOUT_EN.

## Operation
- States: IDLE, REQ, UPDATE, HOLD.
- **IDLE**: entered on reset; moves to REQ on the next cycle.
- **REQ**:
  - imem_req_o=1, imem_addr_o=pc_i.
  - Request stays asserted, with a stable address, until imem_ack_i=1.
  - On ack: latch imem_rdata_i→inst_o and pc_i→inst_pc_o.
  - Next state: UPDATE if stall_i=0, otherwise HOLD.
- **HOLD**: imem_req_o=0; outputs unchanged. Moves to UPDATE when stall_i=0.
- **UPDATE** (one cycle):
  - pc_write_o=1, inst_valid_o=1, pc_next_o=inst_pc_o+4 (modulo 2^32).
  - Next state: REQ.
- **Redirect**:
  - A redirect_i pulse in any state sets an internal kill flag and latches redirect_pc_i. Only the latest redirect is kept.
  - An instruction whose fetch or hold overlaps a redirect is discarded: inst_valid_o=0 in its UPDATE cycle.
  - That UPDATE writes pc_next_o = the latched target. The kill flag clears at the end of UPDATE.
  - A redirect in IDLE takes effect at the first UPDATE.
- **Priority**:
  - Redirect overrides stall. In HOLD, a pending kill moves to UPDATE even with stall_i=1; inst_valid_o stays 0.
  - A redirect in the same cycle as ack is treated as a kill.
- **Outside UPDATE**: pc_write_o=0 and inst_valid_o=0.
- **Reset mid-request**:
  - The request is abandoned and the state returns to IDLE.
  - An ack arriving while not in REQ is ignored.
- **Reset values**: imem_req_o=0, imem_addr_o=0, pc_write_o=0, pc_next_o=RESET_PC, inst_o=0, inst_pc_o=0, inst_valid_o=0, fetch_err_o=0, kill flag=0.

## Timing
- All outputs are registered or decoded from state only; no combinational path from input to output.
- Zero-wait memory (ack in the first REQ cycle): REQ→UPDATE→REQ, one instruction per 2 cycles.
- The PC register updates at the end of UPDATE, so the next REQ presents the new pc_i.
- Each wait cycle adds one cycle of latency.
- Fetch data leaves on inst_o in the cycle after ack, or after the stall releases.

## Configuration
- **FETCH_TIMEOUT_EN defined**:
  - A wait counter runs in REQ and clears on entering REQ.
  - At TIMEOUT_CYCLES cycles without ack: deassert the request and go to UPDATE with inst_valid_o=0 and pc_next_o=pc_i, which re-fetches the same address.
  - fetch_err_o is set sticky until reset.
- **Not defined**: no counter, no fetch_err_o port; REQ waits indefinitely.

## Structure
- Shared package: state encoding (2-bit enum IDLE/REQ/UPDATE/HOLD), INST_W=32, PC_STEP=4.
- Single module, no sub-module. The timeout counter stays inline under the macro.

## Test plan
- Reset, then zero-wait memory returning 0x8C01_0004 at 0x0: UPDATE with inst_valid_o=1, inst_pc_o=0, pc_next_o=4. The next request is at 0x4, two cycles later.
- Ack delayed 3 cycles: imem_req_o and imem_addr_o held stable for 4 cycles. Exactly one pc_write_o pulse.
- stall_i=1 for 5 cycles across ack: HOLD with no pc_write_o. UPDATE occurs the cycle after stall_i falls.
- redirect_i with target 0x40 during a REQ waiting at 0x8: the fetched word is dropped (inst_valid_o=0), pc_next_o=0x40, the next request is at 0x40.
- Redirect and stall together in HOLD: UPDATE next cycle, pc_next_o=target.
- With the macro: no ack for 16 cycles → fetch_err_o=1, pc_next_o=pc_i, then the re-request is issued. Reset asserted mid-REQ → imem_req_o=0 the next cycle.
